pool_wb_writer: RTL and testbench
=================================

# pool_wb_writer

Producer-side writer for the pooling-result buffer that the BRAM DMA later drains. It accepts the pooled pixel stream from the pooling unit and writes it into the block-organised source buffer at `{block, addr}`. Write order is channel-major: CONV1 is 6 blocks × 196 pixels, CONV2 is 16 blocks × 25 pixels. After the final write has landed, it issues the one-cycle `start` code that kicks the DMA.

## Interface

Parameters:
- `DATA_WIDTH`, 8: pixel width.
- `BLK_BITS`, 4: block-select field width.
- `ADDR_BITS`, 10: in-block address width.
- `CONV1_BURST`, 196: pixels per block, mode 0.
- `CONV1_BLOCKS`, 6: blocks, mode 0.
- `CONV2_BURST`, 25: pixels per block, mode 1.
- `CONV2_BLOCKS`, 16: blocks, mode 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous active-high reset.
- `start_i` input 1: arm a frame; sampled in IDLE only.
- `nth_conv_i` input 2: layer select; 0 = CONV1, 1 = CONV2; sampled with `start_i`.
- `pool_valid_i` input 1: pixel valid.
- `pool_ready_o` output 1: pixel accept.
- `pool_data_i` input `DATA_WIDTH`: pixel.
- `wr_en_o` output 1: buffer write enable.
- `wr_ptr_o` output `BLK_BITS+ADDR_BITS` (14): `{block[3:0], addr[9:0]}`.
- `wr_data_o` output `DATA_WIDTH`: write data.
- `start_o` output 2: DMA kick code; 2'b01 for one cycle per completed frame, else 0.
- `busy_o` output 1: high in any state other than IDLE.
- `overrun_o` output 1: sticky drop flag; see Configuration.

## Operation

- **States:** IDLE, FILL, FLUSH, DONE.
- **IDLE:**
  - On `start_i=1` with `nth_conv_i` ∈ {0,1}: latch burst and block count for that mode, clear `blk`/`addr` to 0, go to FILL.
  - On `start_i=1` with `nth_conv_i` ∈ {2,3}: ignored; stay in IDLE.
- **FILL:**
  - `pool_ready_o=1`.
  - A handshake (`valid & ready`) registers a write of `pool_data_i` at `{blk, addr}`.
  - After each handshake, `addr` increments. When `addr == burst-1` it wraps to 0 and `blk` increments.
  - When the handshake is at `addr == burst-1` and `blk == blocks-1`, go to FLUSH.
- **FLUSH:** `pool_ready_o=0`. The final write is on the bus this cycle. Go to DONE.
- **DONE:** `start_o=2'b01` for exactly one cycle, then go to IDLE.
- `start_i` is ignored outside IDLE; the active frame continues unaffected.
- Pointer arithmetic is unsigned; `addr` never reaches `burst`, and `blk` never exceeds `blocks-1` while writing.
- Outside a registered write, `wr_ptr_o` and `wr_data_o` are driven to 0.

## Timing

- **Reset value of every output:** 0 (`pool_ready_o`, `wr_en_o`, `wr_ptr_o`, `wr_data_o`, `start_o`, `busy_o`, `overrun_o`).
- **Arm latency:** `start_i` sampled at edge N → FILL and `pool_ready_o=1` from cycle N+1.
- **Write latency:** handshake at cycle N → `wr_en_o=1` with that beat's pointer and data during cycle N+1. Writes are fully registered; there is no combinational path from `pool_*` to `wr_*`.
- **Throughput:** 1 pixel per cycle. Gaps in `pool_valid_i` stall the counters and emit no writes.
- **Frame end:** last handshake at cycle N → last write in N+1 (FLUSH) → `start_o=01` in N+2 (DONE) → IDLE and `busy_o=0` at N+3.
  - The earliest re-arm is `start_i` sampled at N+3.
- **Reset mid-frame:** immediate return to IDLE and all outputs 0. No `start_o` pulse is issued; a partial frame is abandoned.

## Configuration

- **Macro:** `POOL_WB_OVERRUN_CHK_EN`.
- **Defined:** `overrun_o` becomes sticky-high on the cycle after `pool_valid_i=1` while `pool_ready_o=0` (state IDLE, FLUSH or DONE).
  - The beat is dropped.
  - The flag is cleared by reset or by an accepted `start_i`.
  - Write behaviour is otherwise unchanged.
- **Undefined:** `overrun_o` is tied to 0 and no check logic is compiled in.

## Test plan

- **CONV1, continuous valid:** `nth_conv_i=0`, `start_i` pulse, 1176 beats of data = index[7:0].
  - Exactly 1176 writes.
  - First write ptr 0x0000.
  - Ptr 0x00C3 is followed by 0x0400 (block wrap).
  - Last write ptr 0x14C3 = {5,195}.
  - `start_o=01` exactly 2 cycles after the last handshake, width 1.
- **CONV2 with random valid gaps:** `nth_conv_i=1`.
  - 400 writes in order.
  - Last ptr 0x3C18 = {15,24}.
  - No write in any gap cycle.
  - Single `start_o` pulse.
- **Invalid mode:** `nth_conv_i=2`, `start_i=1`.
  - Stays in IDLE; `busy_o=0`, `pool_ready_o=0`.
  - No writes and no `start_o`.
- **Reset mid-frame:** assert `rst` after 100 CONV1 beats.
  - All outputs 0 in the same cycle.
  - No `start_o`.
  - A following CONV2 frame starts at ptr 0x0000 and completes normally.
- **`start_i` during FILL:** ignored; the frame completes with exactly the original mode's write count.
- **Overrun (macro defined):** `pool_valid_i=1` held for 3 cycles after the last handshake.
  - Those beats are not written.
  - `overrun_o=1` and held.
  - Cleared by the next accepted `start_i`.
  - With the macro undefined, `overrun_o` stays 0.

Source files
------------

// File: rtl/pool_wb_writer_if.sv
// Bundle of pool_wb_writer's control, pooled-pixel stream, buffer-write and status signals.
// The master modport drives the pixel stream and control; the slave modport is the writer.
interface pool_wb_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BLK_BITS   = 4,
  parameter int ADDR_BITS  = 10
);
  logic                          start_i;
  logic [1:0]                    nth_conv_i;
  logic                          pool_valid_i;
  logic                          pool_ready_o;
  logic [DATA_WIDTH-1:0]         pool_data_i;
  logic                          wr_en_o;
  logic [BLK_BITS+ADDR_BITS-1:0] wr_ptr_o;
  logic [DATA_WIDTH-1:0]         wr_data_o;
  logic [1:0]                    start_o;
  logic                          busy_o;
  logic                          overrun_o;

  modport master (
    output start_i, nth_conv_i, pool_valid_i, pool_data_i,
    input  pool_ready_o, wr_en_o, wr_ptr_o, wr_data_o, start_o, busy_o, overrun_o
  );

  modport slave (
    input  start_i, nth_conv_i, pool_valid_i, pool_data_i,
    output pool_ready_o, wr_en_o, wr_ptr_o, wr_data_o, start_o, busy_o, overrun_o
  );
endinterface

// File: rtl/pool_wb_writer.sv
// Writes the pooled pixel stream channel-major into the {block, addr} source buffer, then pulses
// the DMA start code. Optional sticky drop detection is enabled by POOL_WB_OVERRUN_CHK_EN.
module pool_wb_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLK_BITS     = 4,
  parameter int ADDR_BITS    = 10,
  parameter int CONV1_BURST  = 196,
  parameter int CONV1_BLOCKS = 6,
  parameter int CONV2_BURST  = 25,
  parameter int CONV2_BLOCKS = 16
) (
  input logic              clk,
  input logic              rst,
  pool_wb_writer_if.slave  bus
);
  localparam int PTR_BITS = BLK_BITS + ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [ADDR_BITS-1:0]  last_addr_q, last_addr_d;
  logic [BLK_BITS-1:0]   blk_q, blk_d;
  logic [BLK_BITS-1:0]   last_blk_q, last_blk_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  hs_s;
  logic                  arm_s;

  assign hs_s  = bus.pool_valid_i & ready_q;
  // Only modes 0 and 1 exist; codes 2 and 3 leave the writer idle.
  assign arm_s = (state_q == IDLE) & bus.start_i & ~bus.nth_conv_i[1];

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    blk_d       = blk_q;
    last_addr_d = last_addr_q;
    last_blk_d  = last_blk_q;
    ready_d     = ready_q;
    wr_en_d     = 1'b0;
    wr_ptr_d    = {PTR_BITS{1'b0}};
    wr_data_d   = {DATA_WIDTH{1'b0}};
    start_d     = 2'b00;
    case (state_q)
      IDLE: begin
        if (arm_s) begin
          state_d = FILL;
          ready_d = 1'b1;
          addr_d  = {ADDR_BITS{1'b0}};
          blk_d   = {BLK_BITS{1'b0}};
          if (bus.nth_conv_i[0]) begin
            last_addr_d = ADDR_BITS'(CONV2_BURST - 1);
            last_blk_d  = BLK_BITS'(CONV2_BLOCKS - 1);
          end else begin
            last_addr_d = ADDR_BITS'(CONV1_BURST - 1);
            last_blk_d  = BLK_BITS'(CONV1_BLOCKS - 1);
          end
        end else begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      FILL: begin
        if (hs_s) begin
          wr_en_d   = 1'b1;
          wr_ptr_d  = {blk_q, addr_q};
          wr_data_d = bus.pool_data_i;
          if (addr_q == last_addr_q) begin
            addr_d = {ADDR_BITS{1'b0}};
            if (blk_q == last_blk_q) begin
              // Final beat: stop accepting so the flush cycle carries only this write.
              blk_d   = {BLK_BITS{1'b0}};
              state_d = FLUSH;
              ready_d = 1'b0;
            end else begin
              blk_d = blk_q + BLK_BITS'(1);
            end
          end else begin
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end else begin
          state_d = FILL;
        end
      end
      FLUSH: begin
        state_d = DONE;
        ready_d = 1'b0;
        start_d = 2'b01;
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_BITS{1'b0}};
      blk_q       <= {BLK_BITS{1'b0}};
      last_addr_q <= {ADDR_BITS{1'b0}};
      last_blk_q  <= {BLK_BITS{1'b0}};
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_ptr_q    <= {PTR_BITS{1'b0}};
      wr_data_q   <= {DATA_WIDTH{1'b0}};
      start_q     <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      blk_q       <= blk_d;
      last_addr_q <= last_addr_d;
      last_blk_q  <= last_blk_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

`ifdef POOL_WB_OVERRUN_CHK_EN
  logic overrun_q, overrun_d;
  logic drop_s;

  assign drop_s = bus.pool_valid_i & ~ready_q;

  // Sticky drop flag; a drop in the arming cycle still sets it.
  always_comb begin
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (arm_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun_o = overrun_q;
`else
  assign bus.overrun_o = 1'b0;
`endif

  assign bus.pool_ready_o = ready_q;
  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_ptr_o     = wr_ptr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.start_o      = start_q;
  assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_pool_wb_writer.sv
// Randomized scoreboard bench for pool_wb_writer: the driver pushes expected writes/start pulses
// computed from beat index arithmetic; a negedge monitor pops and compares.
module tb_pool_wb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [13:0] ptr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  start_q[$];

  pool_wb_writer_if #(.DATA_WIDTH(8), .BLK_BITS(4), .ADDR_BITS(10)) bus ();

  pool_wb_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every bus write and start pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t e;
    int  sc;
    if (!rst) begin
      if (bus.wr_en_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {18'd0, bus.wr_ptr_o}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_ptr", {18'd0, bus.wr_ptr_o}, {18'd0, e.ptr});
          chk("wr_data", {24'd0, bus.wr_data_o}, {24'd0, e.data});
          chk("wr_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_bus_zero", {10'd0, bus.wr_ptr_o, bus.wr_data_o}, 32'd0);
      end
      if (bus.start_o != 2'b00) begin
        if (start_q.size() == 0) begin
          chk("unexpected_start", {30'd0, bus.start_o}, 32'd0);
        end else begin
          sc = start_q.pop_front();
          chk("start_code", {30'd0, bus.start_o}, 32'd1);
          chk("start_cycle", cyc, sc);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic arm(input logic [1:0] mode);
    @(posedge clk); #1;
    bus.start_i    = 1'b1;
    bus.nth_conv_i = mode;
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
    bus.nth_conv_i = 2'd0;
  endtask

  // Drive one frame; abort_at>0 stops after that many beats, ovr_hold keeps valid high after the end.
  task automatic frame(input int mode, input bit gaps, input int stray_at,
                       input int abort_at, input int ovr_hold);
    int burst, total, n, last_cyc;
    wr_t e;
    burst = (mode == 1) ? 25 : 196;
    total = (mode == 1) ? 400 : 1176;
    n     = (abort_at > 0) ? abort_at : total;
    last_cyc = 0;
    arm(2'(mode));
    chk("arm_ready", {31'd0, bus.pool_ready_o}, 32'd1);
    chk("arm_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("arm_overrun_clear", {31'd0, bus.overrun_o}, 32'd0);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.pool_valid_i = 1'b0;
          bus.pool_data_i  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      if (k == stray_at) begin
        bus.start_i    = 1'b1;
        bus.nth_conv_i = (mode == 1) ? 2'd0 : 2'd1;
      end
      bus.pool_valid_i = 1'b1;
      bus.pool_data_i  = gaps ? 8'($urandom) : 8'(k);
      chk("fill_ready", {31'd0, bus.pool_ready_o}, 32'd1);
      e.ptr  = 14'(((k / burst) << 10) | (k % burst));
      e.data = bus.pool_data_i;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      last_cyc = cyc;
      @(posedge clk); #1;
      bus.start_i    = 1'b0;
      bus.nth_conv_i = 2'd0;
    end
    if (abort_at > 0) begin
      bus.pool_valid_i = 1'b0;
      return;
    end
    start_q.push_back(last_cyc + 2);
    bus.pool_valid_i = (ovr_hold > 0);
    bus.pool_data_i  = 8'hA5;
    repeat ((ovr_hold > 0) ? ovr_hold : 3) begin
      @(posedge clk); #1;
    end
    bus.pool_valid_i = 1'b0;
    chk("end_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("end_ready", {31'd0, bus.pool_ready_o}, 32'd0);
  endtask

  initial begin
    logic exp_ovr;
`ifdef POOL_WB_OVERRUN_CHK_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    bus.start_i      = 1'b0;
    bus.nth_conv_i   = 2'd0;
    bus.pool_valid_i = 1'b0;
    bus.pool_data_i  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.pool_ready_o}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("rst_ptr", {18'd0, bus.wr_ptr_o}, 32'd0);
    chk("rst_data", {24'd0, bus.wr_data_o}, 32'd0);
    chk("rst_start", {30'd0, bus.start_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun_o}, 32'd0);
    rst = 1'b0;

    // CONV1, continuous valid, data = index
    frame(0, 1'b0, -1, 0, 0);

    // Invalid mode 2 stays idle
    arm(2'd2);
    chk("bad_mode_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("bad_mode_ready", {31'd0, bus.pool_ready_o}, 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // CONV2 with random gaps
    frame(1, 1'b1, -1, 0, 0);

    // Reset after 100 CONV1 beats
    frame(0, 1'b0, -1, 100, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, bus.pool_ready_o}, 32'd0);
    chk("midrst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("midrst_ptr", {18'd0, bus.wr_ptr_o}, 32'd0);
    chk("midrst_start", {30'd0, bus.start_o}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("midrst_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    frame(1, 1'b1, -1, 0, 0);

    // Stray start during FILL, then valid held past the final beat
    frame(1, 1'b0, 10, 0, 3);
    chk("overrun_set", {31'd0, bus.overrun_o}, {31'd0, exp_ovr});
    repeat (4) @(posedge clk);
    #1;
    chk("overrun_held", {31'd0, bus.overrun_o}, {31'd0, exp_ovr});
    frame(1, 1'b1, -1, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("writes_drained", exp_q.size(), 32'd0);
    chk("starts_drained", start_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
